// File: rtl/plru_pkg.sv
// Shared types and tree-walk helpers for the tree pseudo-LRU controller.
// Helpers work on a 16-way-wide tree; callers pass the real tree depth.
package plru_pkg;

  typedef enum logic {INIT, READY} plru_state_t;

  localparam int MAX_ASSOC  = 16;
  localparam int MAX_LEVELS = 4;
  localparam int TREE_BITS  = MAX_ASSOC - 1;

  typedef logic [TREE_BITS-1:0]  tree_t;
  typedef logic [MAX_LEVELS-1:0] way_t;

  // Follow the node bits from the root; each level shifts in one way-index bit.
  function automatic way_t plru_victim(tree_t bits, int levels);
    way_t way;
    way_t node;
    logic b;
    way  = '0;
    node = '0;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        b    = bits[node];
        way  = {way[MAX_LEVELS-2:0], b};
        node = (node << 1) + 4'd1 + {3'b000, b};
      end
    end
    return way;
  endfunction

  // Point every node on the path to `way` away from it; off-path bits keep their value.
  function automatic tree_t plru_update(tree_t bits, way_t way, int levels);
    tree_t res;
    way_t  node;
    way_t  wsh;
    logic  d;
    res  = bits;
    node = '0;
    wsh  = way << (MAX_LEVELS - levels);
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        d         = wsh[MAX_LEVELS-1];
        res[node] = ~d;
        node      = (node << 1) + 4'd1 + {3'b000, d};
        wsh       = wsh << 1;
      end
    end
    return res;
  endfunction

  // Nodes touched by an access to `way`; used as a bit write-enable so no read is needed.
  function automatic tree_t plru_path_mask(way_t way, int levels);
    tree_t res;
    way_t  node;
    way_t  wsh;
    logic  d;
    res  = '0;
    node = '0;
    wsh  = way << (MAX_LEVELS - levels);
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        d         = wsh[MAX_LEVELS-1];
        res[node] = 1'b1;
        node      = (node << 1) + 4'd1 + {3'b000, d};
        wsh       = wsh << 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/plru_state_ram.sv
// Per-set tree-bit storage: synchronous bit-masked write, asynchronous read.
module plru_state_ram #(
  parameter int DATA_W   = 3,
  parameter int NUM_SETS = 64,
  localparam int IDX_W   = $clog2(NUM_SETS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wmask,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NUM_SETS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/plru_tree_ctrl.sv
// Tree pseudo-LRU replacement controller with self-initialising set storage.
// Optional macro PLRU_INVALID_FIRST_EN: prefer the lowest invalid way over the tree.
module plru_tree_ctrl #(
  parameter int ASSOC    = 4,
  parameter int NUM_SETS = 64,
  localparam int WAY_W   = $clog2(ASSOC),
  localparam int IDX_W   = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lkp_valid,
  input  logic [IDX_W-1:0] lkp_index,
`ifdef PLRU_INVALID_FIRST_EN
  input  logic [ASSOC-1:0] lkp_way_valid,
`endif
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [WAY_W-1:0] upd_way,
  output logic             ready
);
  import plru_pkg::*;

  localparam int LEVELS = WAY_W;
  localparam int NODE_W = ASSOC - 1;

  plru_state_t       state;
  logic [IDX_W-1:0]  init_cnt;
  logic              upd_acc;
  logic              lkp_acc;
  logic              bypass;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_index;
  logic [NODE_W-1:0] wr_mask;
  logic [NODE_W-1:0] wr_bits;
  logic [NODE_W-1:0] rd_bits;
  logic [NODE_W-1:0] lkp_bits_p0;
  logic [WAY_W-1:0]  tree_way_p0;
  logic [WAY_W-1:0]  victim_way_p0;

  assign upd_acc = upd_valid & ready;
  assign lkp_acc = lkp_valid & ready;
  assign bypass  = upd_acc & lkp_valid & (upd_index == lkp_index);

  always_comb begin
    wr_en    = 1'b0;
    wr_index = upd_index;
    wr_mask  = '0;
    wr_bits  = '0;
    if (state == INIT) begin
      wr_en    = 1'b1;
      wr_index = init_cnt;
      wr_mask  = '1;
    end else begin
      wr_en    = upd_acc;
      wr_mask  = NODE_W'(plru_path_mask(MAX_LEVELS'(upd_way), LEVELS));
      wr_bits  = NODE_W'(plru_update('0, MAX_LEVELS'(upd_way), LEVELS));
    end
  end

  plru_state_ram #(
    .DATA_W   (NODE_W),
    .NUM_SETS (NUM_SETS)
  ) u_state_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_index),
    .wmask (wr_mask),
    .wdata (wr_bits),
    .raddr (lkp_index),
    .rdata (rd_bits)
  );

  // Stage p0: read, same-set update bypass and victim selection
  always_comb begin
    lkp_bits_p0 = rd_bits;
    if (bypass)
      lkp_bits_p0 = NODE_W'(plru_update(TREE_BITS'(rd_bits), MAX_LEVELS'(upd_way), LEVELS));
    tree_way_p0   = WAY_W'(plru_victim(TREE_BITS'(lkp_bits_p0), LEVELS));
    victim_way_p0 = tree_way_p0;
`ifdef PLRU_INVALID_FIRST_EN
    for (int i = ASSOC - 1; i >= 0; i--) begin
      if (!lkp_way_valid[i]) victim_way_p0 = WAY_W'(i);
    end
`endif
  end

  // Stage p1: registered victim and control FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      init_cnt     <= '0;
      ready        <= 1'b0;
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      victim_valid <= lkp_acc;
      if (lkp_acc) victim_way <= victim_way_p0;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + IDX_W'(1);
          if (init_cnt == IDX_W'(NUM_SETS - 1)) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY:   ready <= 1'b1;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_plru_tree_ctrl.sv
// Directed bench for plru_tree_ctrl (ASSOC=4, NUM_SETS=64).
module tb_plru_tree_ctrl;

  logic       clk;
  logic       rst;
  logic       lkp_valid;
  logic [5:0] lkp_index;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic       upd_valid;
  logic [5:0] upd_index;
  logic [1:0] upd_way;
  logic       ready;
`ifdef PLRU_INVALID_FIRST_EN
  logic [3:0] lkp_way_valid;
`endif

  int n_assert;
  int n_fail;

  plru_tree_ctrl #(
    .ASSOC    (4),
    .NUM_SETS (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lkp_valid     (lkp_valid),
    .lkp_index     (lkp_index),
`ifdef PLRU_INVALID_FIRST_EN
    .lkp_way_valid (lkp_way_valid),
`endif
    .victim_valid  (victim_valid),
    .victim_way    (victim_way),
    .upd_valid     (upd_valid),
    .upd_index     (upd_index),
    .upd_way       (upd_way),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int idx, input int way);
    upd_valid = 1'b1;
    upd_index = 6'(idx);
    upd_way   = 2'(way);
    step();
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input int idx, input int exp_way);
    lkp_valid = 1'b1;
    lkp_index = 6'(idx);
    step();
    lkp_valid = 1'b0;
    check({tag, "_vv"}, 32'(victim_valid), 32'd1);
    check({tag, "_way"}, 32'(victim_way), 32'(exp_way));
  endtask

  int n;

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    lkp_valid = 1'b0;
    lkp_index = '0;
    upd_valid = 1'b0;
    upd_index = '0;
    upd_way   = '0;
`ifdef PLRU_INVALID_FIRST_EN
    lkp_way_valid = 4'b1111;
`endif
    step();
    step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_vv", 32'(victim_valid), 32'd0);
    check("rst_way", 32'(victim_way), 32'd0);

    // Sweep: a lookup and a late update on an already-swept set must both be ignored
    rst = 1'b0;
    n = 0;
    while (n < 200 && !ready) begin
      lkp_valid = (n == 10);
      lkp_index = 6'd3;
      upd_valid = (n == 40);
      upd_index = 6'd3;
      upd_way   = 2'd0;
      step();
      n++;
      if (n == 11) check("init_lkp_vv", 32'(victim_valid), 32'd0);
    end
    lkp_valid = 1'b0;
    upd_valid = 1'b0;
    check("init_cycles", 32'(n), 32'd64);
    lookup("init_upd_ignored", 3, 0);

    // Set 5: touch every way in order, way0 is oldest
    for (int w = 0; w < 4; w++) upd(5, w);
    lookup("set5", 5, 0);
    step();
    check("set5_pulse_end", 32'(victim_valid), 32'd0);

    // Set 7
    upd(7, 2);
    lookup("set7_a", 7, 0);
    upd(7, 0);
    lookup("set7_b", 7, 3);

    // Back-to-back lookups
    lkp_valid = 1'b1;
    lkp_index = 6'd7;
    step();
    check("b2b_0_vv", 32'(victim_valid), 32'd1);
    check("b2b_0_way", 32'(victim_way), 32'd3);
    lkp_index = 6'd5;
    step();
    lkp_valid = 1'b0;
    check("b2b_1_vv", 32'(victim_valid), 32'd1);
    check("b2b_1_way", 32'(victim_way), 32'd0);
    step();
    check("b2b_end_vv", 32'(victim_valid), 32'd0);

    // Same-cycle update and lookup of set 9 use the updated bits
    lkp_valid = 1'b1;
    lkp_index = 6'd9;
    upd_valid = 1'b1;
    upd_index = 6'd9;
    upd_way   = 2'd0;
    step();
    lkp_valid = 1'b0;
    upd_valid = 1'b0;
    check("bypass_vv", 32'(victim_valid), 32'd1);
    check("bypass_way", 32'(victim_way), 32'd2);
    lookup("bypass_kept", 9, 2);

    // Different indices in the same cycle are independent
    lkp_valid = 1'b1;
    lkp_index = 6'd12;
    upd_valid = 1'b1;
    upd_index = 6'd13;
    upd_way   = 2'd0;
    step();
    lkp_valid = 1'b0;
    upd_valid = 1'b0;
    check("indep_way", 32'(victim_way), 32'd0);
    lookup("indep_13", 13, 2);

    // Update followed directly by lookup
    upd(11, 1);
    lookup("next_a", 11, 2);
    upd(11, 2);
    lookup("next_b", 11, 0);

`ifdef PLRU_INVALID_FIRST_EN
    lkp_way_valid = 4'b1011;
    lookup("inv_first", 7, 2);
    lkp_way_valid = 4'b1111;
    lookup("all_valid", 20, 0);
`endif

    // Reset during the sweep restarts it
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_ready", 32'(ready), 32'd0);
    check("rst2_vv", 32'(victim_valid), 32'd0);
    for (int i = 0; i < 20; i++) step();
    check("mid_sweep_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (n < 200 && !ready) begin
      step();
      n++;
    end
    check("resweep_cycles", 32'(n), 32'd64);
    lookup("resweep_set5", 5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
